// File: rtl/dm_responder.sv
// dm_responder: data-memory target for the core's DM port.
// Word-organised SRAM with per-byte write lanes, a one-cycle registered read
// and OE-gated read data. A valid/ready backdoor port preloads whole words
// whenever the CPU is not selecting the memory.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_DM_CS           chip select, one access per edge while high
//   i_DM_WEB[3:0]     active-low byte write enables (4'b1111 = read)
//   i_DM_addr[31:0]   byte address, word index = addr[log2(DEPTH)+1:2]
//   i_DM_DI[31:0]     lane-aligned write data
//   i_DM_OE           output enable for o_DM_DO
//   o_DM_DO[31:0]     read register when OE=1, else 0
//   i_ld_valid        backdoor load request
//   i_ld_addr[31:0]   backdoor word index
//   i_ld_data[31:0]   backdoor write word
//   o_ld_ready        backdoor accept (= !i_DM_CS)
//   o_err             one-cycle pulse after an out-of-range access
//   o_rd_cnt          in-range CPU read count (wraps)
//   o_wr_cnt          in-range CPU write count (wraps)
module dm_responder #(
  parameter int unsigned DEPTH = 16384,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_DM_CS,
  input  logic [3:0]       i_DM_WEB,
  input  logic [31:0]      i_DM_addr,
  input  logic [31:0]      i_DM_DI,
  input  logic             i_DM_OE,
  output logic [31:0]      o_DM_DO,
  input  logic             i_ld_valid,
  input  logic [31:0]      i_ld_addr,
  input  logic [31:0]      i_ld_data,
  output logic             o_ld_ready,
  output logic             o_err,
  output logic [CNT_W-1:0] o_rd_cnt,
  output logic [CNT_W-1:0] o_wr_cnt
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned DW    = 32;
  localparam int unsigned LANES = 4;

  logic [DW-1:0]    mem [DEPTH];
  logic [DW-1:0]    rd_q;
  logic             err_q;
  logic [CNT_W-1:0] rd_cnt_q;
  logic [CNT_W-1:0] wr_cnt_q;

  logic [AW-1:0]    cpu_idx;
  logic [AW-1:0]    ld_idx;
  logic             cpu_in_range;
  logic             ld_in_range;
  logic             cpu_rd;
  logic             cpu_wr;
  logic             ld_fire;

  // Address decode and access classification.
  always_comb begin
    cpu_idx      = i_DM_addr[AW+1:2];
    ld_idx       = i_ld_addr[AW-1:0];
    cpu_in_range = (i_DM_addr >> (AW + 2)) == 32'(0);
    ld_in_range  = i_ld_addr < 32'(DEPTH);
    cpu_rd       = i_DM_CS && (i_DM_WEB == 4'hF);
    cpu_wr       = i_DM_CS && (i_DM_WEB != 4'hF);
    ld_fire      = i_ld_valid && o_ld_ready;
  end

  // The CPU owns the array whenever it selects it.
  assign o_ld_ready = !i_DM_CS;

  // Array writes share the reset-qualified block so no write lands on an
  // edge where rst is high; the array itself is never cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q     <= '0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      err_q <= (i_DM_CS && !cpu_in_range) || (ld_fire && !ld_in_range);

      if (cpu_wr && cpu_in_range) begin
        for (int n = 0; n < int'(LANES); n++) begin
          if (!i_DM_WEB[n]) begin
            mem[cpu_idx][8*n +: 8] <= i_DM_DI[8*n +: 8];
          end
        end
        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end else if (ld_fire && ld_in_range) begin
        mem[ld_idx] <= i_ld_data;
      end

      // Out-of-range reads clear the read register so stale data never leaks.
      if (cpu_rd) begin
        if (cpu_in_range) begin
          rd_q     <= mem[cpu_idx];
          rd_cnt_q <= rd_cnt_q + CNT_W'(1);
        end else begin
          rd_q <= '0;
        end
      end
    end
  end

  // OE gates the held read register combinationally.
  assign o_DM_DO  = i_DM_OE ? rd_q : '0;
  assign o_err    = err_q;
  assign o_rd_cnt = rd_cnt_q;
  assign o_wr_cnt = wr_cnt_q;

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Synchronous data-memory responder: the target end of the core's DM port (CS / byte-WEB / addr / DI / OE), returning read data on DO.
- Holds a word-organised SRAM array with per-byte write lanes, one-cycle registered read, and OE-gated output.
- A valid/ready backdoor load port lets the bench or boot logic preload words; CPU traffic always has priority.
- Out-of-range detection and read/write access counters are provided for debug and verification.

Parameters:
- DEPTH, 16384, number of 32-bit words (power of two, at least 4).
- CNT_W, 32, width of each access counter.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- i_DM_CS, input, 1, chip select; an access occurs on every edge where this is 1.
- i_DM_WEB, input, 4, active-low byte write enables; bit n gates byte lane n (bits 8n+7:8n); 4'b1111 = read.
- i_DM_addr, input, 32, byte address; word index = addr[log2(DEPTH)+1:2]; addr[1:0] ignored.
- i_DM_DI, input, 32, write data, already lane-aligned by the core.
- i_DM_OE, input, 1, output enable for o_DM_DO.
- o_DM_DO, output, 32, read data (registered value when OE=1, else 0).
- i_ld_valid, input, 1, backdoor load request.
- i_ld_addr, input, 32, backdoor word index (not byte address).
- i_ld_data, input, 32, backdoor write word (all 4 lanes).
- o_ld_ready, output, 1, backdoor accept; equals !i_DM_CS.
- o_err, output, 1, one-cycle pulse on an out-of-range CPU or backdoor access.
- o_rd_cnt, output, CNT_W, count of accepted in-range CPU reads.
- o_wr_cnt, output, CNT_W, count of accepted in-range CPU writes (any WEB lane low).

Behaviour:
- Reset (async, active-high), outputs:
  - read-data register = 0, so o_DM_DO = 0.
  - o_err = 0; o_rd_cnt = 0; o_wr_cnt = 0.
  - Memory array is NOT reset; contents persist across reset.
  - No write occurs on an edge where rst=1. An access in flight when reset asserts is dropped.
- Range check: in range iff addr[31:log2(DEPTH)+2] == 0 (CPU) or i_ld_addr < DEPTH (backdoor).
- CPU read (CS=1, WEB=4'b1111, in range):
  - The read-data register captures mem[word] at the edge.
  - o_DM_DO shows it from the next cycle while OE=1. Latency is 1 cycle; the core raises OE in the following stage.
  - The register holds its value until the next CPU read. OE only gates the output, combinationally.
- CPU write (CS=1, any WEB bit 0, in range):
  - Each lane n with WEB[n]=0 gets mem[word][lane n] <= DI[lane n]; other lanes are unchanged.
  - The read-data register is unchanged.
- Read-after-write to the same word on consecutive cycles returns the newly written bytes.
- Out-of-range CPU access:
  - No array write; o_err=1 for exactly the next cycle.
  - On a read, the read-data register loads 0. Counters do not increment.
- CS=0: no array access; read register holds.
- Backdoor load:
  - A transfer occurs on an edge where i_ld_valid & o_ld_ready; mem[i_ld_addr] <= i_ld_data (full word).
  - The requester must hold valid/addr/data stable until accepted.
  - Out-of-range backdoor: accepted, no write, o_err pulses.
  - CPU CS=1 forces o_ld_ready=0, so the backdoor never conflicts with the CPU.
- o_err is a registered pulse, high only in the cycle after an offending edge. Back-to-back offending edges keep it high.
- Counters increment by 1 per qualifying edge and wrap modulo 2^CNT_W with no saturation.

Test Plan:
- Reset, then backdoor-load word 5 = 0x11223344 with CS=0 → ready=1 on the accept edge. A CPU read of addr 0x14, then OE=1 next cycle → o_DM_DO = 0x11223344, o_rd_cnt = 1.
- Word 5 = 0x11223344; CPU write addr 0x14, WEB=4'b1100, DI=0xAABBCCDD → following read returns 0x1122CCDD, o_wr_cnt = 1. Then WEB=4'b0111, DI=0x99000000 → read returns 0x9922CCDD.
- Read with OE=0 → o_DM_DO = 0. Raise OE two cycles later with CS=0 throughout → o_DM_DO shows the held value.
- CPU read at addr 0x0001_0000 (DEPTH=16384) → o_err=1 for one cycle, o_DM_DO=0 with OE=1, o_rd_cnt unchanged. Also a backdoor addr of 16384 → o_err pulse, no write.
- i_ld_valid held with CS=1 for 3 cycles → ready=0 and no write. CS drops → load accepted the same cycle.
- Write in progress when rst is pulsed on that edge → the word is unchanged. After release, earlier array contents are intact and all outputs/counters are 0.
